// File: rtl/dac_sar_ctrl.sv
// Controller for the 4-channel DAC/comparator macro: DAC pass-through per channel,
// or an 8-bit successive-approximation conversion on one channel at a time.
module dac_sar_ctrl #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic [3:0] cfg_adc_en,
  input  logic [7:0] cfg_dac0,
  input  logic [7:0] cfg_dac1,
  input  logic [7:0] cfg_dac2,
  input  logic [7:0] cfg_dac3,
  input  logic       conv_start,
  input  logic [1:0] conv_ch,
  input  logic       conv_abort,
  output logic       conv_busy,
  output logic       conv_done,
  output logic       conv_err,
  output logic [7:0] conv_data,
  output logic [1:0] conv_ch_out,
  output logic [7:0] Din0,
  output logic [7:0] Din1,
  output logic [7:0] Din2,
  output logic [7:0] Din3,
  output logic       SAMPLE0,
  output logic       SAMPLE1,
  output logic       SAMPLE2,
  output logic       SAMPLE3,
  output logic       SEL0,
  output logic       SEL1,
  output logic       SEL2,
  output logic       SEL3,
  input  logic       RESULT0,
  input  logic       RESULT1,
  input  logic       RESULT2,
  input  logic       RESULT3,
  output logic [2:0] dbg_state
);

  // Request/response: conv_start is a one-cycle request accepted only in IDLE;
  // each accepted request ends in exactly one conv_done pulse unless aborted or
  // reset, and a start on a DAC-mode channel is answered by a conv_err pulse.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] trial_q, trial_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] res_meta_q, res_s_q;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] data_q, data_d;
  logic [1:0] ch_out_q, ch_out_d;
  logic [7:0] din_q [4];
  logic [7:0] din_d [4];
  logic [3:0] sample_q, sample_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] cfg_dac [4];
  logic [7:0] trial_nx;
  logic [2:0] bit_dec;

  assign cfg_dac[0] = cfg_dac0;
  assign cfg_dac[1] = cfg_dac1;
  assign cfg_dac[2] = cfg_dac2;
  assign cfg_dac[3] = cfg_dac3;
  assign bit_dec    = bit_q - 3'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    trial_d  = trial_q;
    ch_d     = ch_q;
    err_d    = 1'b0;
    trial_nx = trial_q;
    case (state_q)
      ST_IDLE: begin
        if (conv_start) begin
          if (cfg_adc_en[conv_ch]) begin
            ch_d    = conv_ch;
            trial_d = 8'h00;
            cnt_d   = 8'd0;
            state_d = ST_SAMPLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = 8'd0;
          bit_d   = 3'd7;
          trial_d = 8'h80;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 8'd0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DECIDE: begin
        // Comparator low means the trial overshot Vin: drop this bit.
        if (!res_s_q[ch_q]) trial_nx[bit_q] = 1'b0;
        if (bit_q != 3'd0) begin
          trial_nx[bit_dec] = 1'b1;
          bit_d   = bit_dec;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_DONE;
        end
        trial_d = trial_nx;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (conv_abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    data_d   = (state_d == ST_DONE) ? trial_d : data_q;
    ch_out_d = (state_d == ST_DONE) ? ch_d : ch_out_q;
    for (int n = 0; n < 4; n++) begin
      if (busy_d && (ch_d == 2'(n))) begin
        din_d[n]    = trial_d;
        sample_d[n] = (state_d == ST_SAMPLE);
        sel_d[n]    = 1'b1;
      end else begin
        din_d[n]    = cfg_dac[n];
        sample_d[n] = 1'b0;
        sel_d[n]    = cfg_adc_en[n];
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 3'd0;
      trial_q    <= 8'h00;
      ch_q       <= 2'd0;
      res_meta_q <= 4'h0;
      res_s_q    <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= 8'h00;
      ch_out_q   <= 2'd0;
      sample_q   <= 4'h0;
      sel_q      <= 4'h0;
      for (int n = 0; n < 4; n++) din_q[n] <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      trial_q    <= trial_d;
      ch_q       <= ch_d;
      res_meta_q <= {RESULT3, RESULT2, RESULT1, RESULT0};
      res_s_q    <= res_meta_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      data_q     <= data_d;
      ch_out_q   <= ch_out_d;
      sample_q   <= sample_d;
      sel_q      <= sel_d;
      for (int n = 0; n < 4; n++) din_q[n] <= din_d[n];
    end
  end

  assign conv_busy   = busy_q;
  assign conv_done   = done_q;
  assign conv_err    = err_q;
  assign conv_data   = data_q;
  assign conv_ch_out = ch_out_q;
  assign Din0        = din_q[0];
  assign Din1        = din_q[1];
  assign Din2        = din_q[2];
  assign Din3        = din_q[3];
  assign SAMPLE0     = sample_q[0];
  assign SAMPLE1     = sample_q[1];
  assign SAMPLE2     = sample_q[2];
  assign SAMPLE3     = sample_q[3];
  assign SEL0        = sel_q[0];
  assign SEL1        = sel_q[1];
  assign SEL2        = sel_q[2];
  assign SEL3        = sel_q[3];
  assign dbg_state   = state_q;

endmodule
